// File: rtl/decoder_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_cycle_sequencer
//  Purpose  : Machine-cycle controller feeding the opcode-table decoder:
//             owns ITABLE, the XPT phase counter and the CM1/CMR/CMA flags.
//  Revision : 1.0  initial release
// ============================================================================
module decoder_cycle_sequencer #(
    parameter logic [7:0]  RESET_OPCODE = 8'h00,
    parameter int unsigned XPT_LIMIT    = 15,
    parameter int unsigned ALU_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       halt,
    input  logic       mem_rd_ack,
    input  logic [7:0] mem_rd_data,
    input  logic       pr_reset_xpt,
    input  logic       p2_set_cm1,
    input  logic       p2_reset_itable,
    input  logic       p2_set_cmr,
    input  logic       p2_set_cma,
    output logic       dec_enable,
    output logic [3:0] xpt,
    output logic [3:0] not_xpt,
    output logic [7:0] itable,
    output logic [7:0] not_itable,
    output logic       cm1,
    output logic       cmr,
    output logic       cma,
    output logic       mem_rd_req,
    output logic [7:0] op_data,
    output logic [7:0] op_data_old,
    output logic       xpt_overflow
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MREAD = 3'd3,
        S_ALU   = 3'd4
    } state_t;

    localparam logic [3:0] c_xpt_limit = 4'(XPT_LIMIT);
    localparam logic [3:0] c_alu_last  = 4'(ALU_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_xpt, w_xpt_nxt;
    logic [7:0] r_itable, w_itable_nxt;
    logic [7:0] r_op_data, w_op_data_nxt;
    logic [7:0] r_op_data_old, w_op_data_old_nxt;
    logic       r_ovf, w_ovf_nxt;
    logic       r_req, w_req_nxt;
    logic [3:0] r_alu_cnt, w_alu_cnt_nxt;
    logic       w_rd_done;

    // r_req is only ever high in FETCH or MREAD, so it qualifies the ack.
    assign w_rd_done = r_req & mem_rd_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_xpt         <= 4'd0;
            r_itable      <= RESET_OPCODE;
            r_op_data     <= 8'd0;
            r_op_data_old <= 8'd0;
            r_ovf         <= 1'b0;
            r_req         <= 1'b0;
            r_alu_cnt     <= 4'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_xpt         <= w_xpt_nxt;
            r_itable      <= w_itable_nxt;
            r_op_data     <= w_op_data_nxt;
            r_op_data_old <= w_op_data_old_nxt;
            r_ovf         <= w_ovf_nxt;
            r_req         <= w_req_nxt;
            r_alu_cnt     <= w_alu_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_xpt_nxt         = r_xpt;
        w_itable_nxt      = r_itable;
        w_op_data_nxt     = r_op_data;
        w_op_data_old_nxt = r_op_data_old;
        w_ovf_nxt         = r_ovf;
        w_alu_cnt_nxt     = r_alu_cnt;

        case (r_state)
            S_IDLE: begin
                if (!halt) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                if (w_rd_done) begin
                    w_itable_nxt = mem_rd_data;
                    w_xpt_nxt    = 4'd0;
                    w_state_nxt  = S_EXEC;
                end
            end

            S_EXEC: begin
                if (p2_reset_itable) begin
                    w_itable_nxt = RESET_OPCODE;
                end
                if (p2_set_cm1) begin
                    w_xpt_nxt   = 4'd0;
                    w_state_nxt = halt ? S_IDLE : S_FETCH;
                end else begin
                    if (p2_set_cmr) begin
                        w_state_nxt = S_MREAD;
                    end else if (p2_set_cma) begin
                        w_state_nxt   = S_ALU;
                        w_alu_cnt_nxt = c_alu_last;
                    end
                    // A cycle request freezes xpt; otherwise it advances or aborts.
                    if (pr_reset_xpt) begin
                        w_xpt_nxt = 4'd0;
                    end else if (!p2_set_cmr && !p2_set_cma) begin
                        if (r_xpt == c_xpt_limit) begin
                            w_ovf_nxt   = 1'b1;
                            w_xpt_nxt   = 4'd0;
                            w_state_nxt = S_FETCH;
                        end else begin
                            w_xpt_nxt = r_xpt + 4'd1;
                        end
                    end
                end
            end

            S_MREAD: begin
                if (w_rd_done) begin
                    w_op_data_old_nxt = r_op_data;
                    w_op_data_nxt     = mem_rd_data;
                    w_xpt_nxt         = r_xpt + 4'd1;
                    w_state_nxt       = S_EXEC;
                end
            end

            S_ALU: begin
                if (r_alu_cnt == 4'd0) begin
                    w_xpt_nxt   = r_xpt + 4'd1;
                    w_state_nxt = S_EXEC;
                end else begin
                    w_alu_cnt_nxt = r_alu_cnt - 4'd1;
                end
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        w_req_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_MREAD);
    end

    assign dec_enable   = (r_state == S_EXEC);
    assign cm1          = (r_state == S_FETCH);
    assign cmr          = (r_state == S_MREAD);
    assign cma          = (r_state == S_ALU);
    assign mem_rd_req   = r_req;
    assign xpt          = r_xpt;
    assign not_xpt      = ~r_xpt;
    assign itable       = r_itable;
    assign not_itable   = ~r_itable;
    assign op_data      = r_op_data;
    assign op_data_old  = r_op_data_old;
    assign xpt_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_decoder_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_cycle_sequencer
//  Purpose  : Directed bench with a cycle-level reference model and checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_cycle_sequencer;

    localparam logic [7:0] RST_OP = 8'h00;
    localparam int         LIMIT  = 15;
    localparam int         ALU_N  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       halt = 1'b0;
    logic       mem_rd_ack = 1'b0;
    logic [7:0] mem_rd_data = 8'h00;
    logic       pr_reset_xpt = 1'b0;
    logic       p2_set_cm1 = 1'b0;
    logic       p2_reset_itable = 1'b0;
    logic       p2_set_cmr = 1'b0;
    logic       p2_set_cma = 1'b0;
    logic       dec_enable, cm1, cmr, cma, mem_rd_req, xpt_overflow;
    logic [3:0] xpt, not_xpt;
    logic [7:0] itable, not_itable, op_data, op_data_old;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cmr = 0;
    int n_cma = 0;

    always #5 clk = ~clk;

    decoder_cycle_sequencer #(
        .RESET_OPCODE (RST_OP),
        .XPT_LIMIT    (LIMIT),
        .ALU_CYCLES   (ALU_N)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .halt            (halt),
        .mem_rd_ack      (mem_rd_ack),
        .mem_rd_data     (mem_rd_data),
        .pr_reset_xpt    (pr_reset_xpt),
        .p2_set_cm1      (p2_set_cm1),
        .p2_reset_itable (p2_reset_itable),
        .p2_set_cmr      (p2_set_cmr),
        .p2_set_cma      (p2_set_cma),
        .dec_enable      (dec_enable),
        .xpt             (xpt),
        .not_xpt         (not_xpt),
        .itable          (itable),
        .not_itable      (not_itable),
        .cm1             (cm1),
        .cmr             (cmr),
        .cma             (cma),
        .mem_rd_req      (mem_rd_req),
        .op_data         (op_data),
        .op_data_old     (op_data_old),
        .xpt_overflow    (xpt_overflow)
    );

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_MREAD = 3, M_ALU = 4;
    int         m_mode = M_FETCH;
    int         m_xpt = 0;
    int         m_alu_left = 0;
    logic [7:0] m_itab = RST_OP;
    logic [7:0] m_opd = 8'h00;
    logic [7:0] m_opo = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_fresh = 1'b1;   // first cycle after reset: no request yet
    bit         m_rd_ok;

    function automatic bit mdl_req();
        return ((m_mode == M_FETCH) || (m_mode == M_MREAD)) && !m_fresh;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_FETCH; m_xpt = 0; m_itab = RST_OP;
            m_opd = 8'h00; m_opo = 8'h00; m_ovf = 1'b0; m_fresh = 1'b1;
            m_alu_left = 0;
        end else begin
            m_rd_ok = mdl_req() && mem_rd_ack;
            m_fresh = 1'b0;
            case (m_mode)
                M_IDLE:  if (!halt) m_mode = M_FETCH;
                M_FETCH: if (m_rd_ok) begin
                    m_itab = mem_rd_data; m_xpt = 0; m_mode = M_EXEC;
                end
                M_MREAD: if (m_rd_ok) begin
                    m_opo = m_opd; m_opd = mem_rd_data;
                    m_xpt = (m_xpt + 1) % 16; m_mode = M_EXEC;
                end
                M_ALU: begin
                    m_alu_left = m_alu_left - 1;
                    if (m_alu_left == 0) begin
                        m_xpt = (m_xpt + 1) % 16; m_mode = M_EXEC;
                    end
                end
                default: begin
                    if (p2_reset_itable) m_itab = RST_OP;
                    if (p2_set_cm1) begin
                        m_xpt = 0; m_mode = halt ? M_IDLE : M_FETCH;
                    end else if (p2_set_cmr) begin
                        m_mode = M_MREAD; if (pr_reset_xpt) m_xpt = 0;
                    end else if (p2_set_cma) begin
                        m_mode = M_ALU; m_alu_left = ALU_N; if (pr_reset_xpt) m_xpt = 0;
                    end else if (pr_reset_xpt) begin
                        m_xpt = 0;
                    end else if (m_xpt == LIMIT) begin
                        m_ovf = 1'b1; m_xpt = 0; m_mode = M_FETCH;
                    end else begin
                        m_xpt = m_xpt + 1;
                    end
                end
            endcase
        end
    end

    logic [45:0] act_v, exp_v;
    always @(negedge clk) begin
        act_v = {dec_enable, cm1, cmr, cma, mem_rd_req, xpt_overflow, xpt, not_xpt,
                 itable, not_itable, op_data, op_data_old};
        exp_v = {m_mode == M_EXEC, m_mode == M_FETCH, m_mode == M_MREAD, m_mode == M_ALU,
                 mdl_req(), m_ovf, 4'(m_xpt), ~(4'(m_xpt)), m_itab, ~m_itab, m_opd, m_opo};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL model_compare t=%0t got %h expected %h", $time, act_v, exp_v);
        end
    end

    always @(negedge clk) begin
        if (cmr === 1'b1) n_cmr++;
        if (cma === 1'b1) n_cma++;
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic clr();
        mem_rd_ack = 1'b0; pr_reset_xpt = 1'b0; p2_set_cm1 = 1'b0;
        p2_reset_itable = 1'b0; p2_set_cmr = 1'b0; p2_set_cma = 1'b0;
    endtask

    initial begin
        int k;
        clr();
        repeat (2) cyc();
        at_neg();
        chk("reset cm1", cm1, 1);
        chk("reset req", mem_rd_req, 0);
        chk("reset not_itable", not_itable, 8'hFF);
        chk("reset dec_enable", dec_enable, 0);
        cyc(); rst_n = 1'b1;

        // first fetch, zero-wait ack at the first request cycle
        cyc(); mem_rd_ack = 1'b1; mem_rd_data = 8'h3C;
        at_neg(); chk("req rises", mem_rd_req, 1);
        cyc(); clr();
        at_neg();
        chk("fetch itable", itable, 8'h3C);
        chk("fetch not_itable", not_itable, 8'hC3);
        chk("exec dec_enable", dec_enable, 1);
        chk("exec xpt0", xpt, 0);
        cyc(); at_neg(); chk("exec xpt1", xpt, 1);
        cyc(); at_neg(); chk("exec xpt2", xpt, 2);
        mem_rd_ack = 1'b1; mem_rd_data = 8'hEE;      // stray ack in EXEC
        cyc(); clr(); at_neg();
        chk("exec xpt3", xpt, 3);
        chk("stray ack ignored", itable, 8'h3C);

        // operand read with three wait cycles
        n_cmr = 0; p2_set_cmr = 1'b1;
        cyc(); clr();
        cyc();
        cyc();
        cyc(); mem_rd_ack = 1'b1; mem_rd_data = 8'hA5;
        cyc(); clr(); at_neg();
        chk("cmr cycles", n_cmr, 4);
        chk("mread xpt", xpt, 4);
        chk("mread op_data", op_data, 8'hA5);

        // second read, zero wait
        p2_set_cmr = 1'b1;
        cyc(); clr(); mem_rd_ack = 1'b1; mem_rd_data = 8'h5A;
        cyc(); clr(); at_neg();
        chk("op_data", op_data, 8'h5A);
        chk("op_data_old", op_data_old, 8'hA5);
        chk("mread2 xpt", xpt, 5);

        // ALU cycle
        n_cma = 0; p2_set_cma = 1'b1;
        cyc(); clr(); at_neg(); chk("alu dec_enable", dec_enable, 0);
        cyc(); at_neg(); chk("alu dec_enable 2", dec_enable, 0);
        cyc(); at_neg();
        chk("cma cycles", n_cma, 2);
        chk("alu xpt", xpt, 6);

        // same-edge cm1 + cmr + reset_xpt
        n_cmr = 0; p2_set_cm1 = 1'b1; p2_set_cmr = 1'b1; pr_reset_xpt = 1'b1;
        cyc(); clr(); at_neg();
        chk("prio cm1", cm1, 1);
        chk("prio xpt", xpt, 0);
        chk("prio no cmr", n_cmr, 0);
        mem_rd_ack = 1'b1; mem_rd_data = 8'h11;
        cyc(); clr(); at_neg(); chk("refetch itable", itable, 8'h11);

        // halt at the fetch boundary; pulses and acks in IDLE ignored
        halt = 1'b1; p2_set_cm1 = 1'b1;
        cyc(); p2_set_cm1 = 1'b0; p2_set_cmr = 1'b1; mem_rd_ack = 1'b1;
        at_neg(); chk("idle cm1", cm1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); at_neg(); chk("idle req", mem_rd_req, 0);
        end
        clr(); halt = 1'b0;
        cyc(); at_neg(); chk("unhalt req", mem_rd_req, 1);
        mem_rd_ack = 1'b1; mem_rd_data = 8'h22;
        cyc(); clr(); at_neg();
        chk("unhalt itable", itable, 8'h22);
        chk("ovf clear", xpt_overflow, 0);

        // overflow: no pulses from xpt=0
        k = 0;
        while (cm1 !== 1'b1 && k < 40) begin
            cyc(); at_neg(); k++;
        end
        chk("overflow exec clocks", k, 16);
        chk("overflow flag", xpt_overflow, 1);
        chk("overflow xpt", xpt, 0);
        mem_rd_ack = 1'b1; mem_rd_data = 8'h33;
        cyc(); clr(); at_neg(); chk("post-ovf itable", itable, 8'h33);

        // reset_itable alone: xpt still advances
        p2_reset_itable = 1'b1;
        cyc(); clr(); at_neg();
        chk("reset_itable", itable, 8'h00);
        chk("reset_itable xpt", xpt, 1);
        p2_set_cm1 = 1'b1;
        cyc(); clr(); mem_rd_ack = 1'b1; mem_rd_data = 8'h55;
        cyc(); clr(); at_neg();
        chk("ovf sticky", xpt_overflow, 1);
        chk("next instr itable", itable, 8'h55);

        // reset during MREAD with a same-cycle ack
        rst_n = 1'b0;
        cyc(); at_neg(); chk("reset clears ovf", xpt_overflow, 0);
        cyc(); rst_n = 1'b1;
        cyc(); mem_rd_ack = 1'b1; mem_rd_data = 8'h44;
        cyc(); clr(); p2_set_cmr = 1'b1;
        cyc(); clr(); mem_rd_ack = 1'b1; mem_rd_data = 8'h99;
        #1 rst_n = 1'b0;
        #1;
        chk("async itable", itable, 8'h00);
        chk("async req", mem_rd_req, 0);
        chk("async cm1", cm1, 1);
        cyc(); clr(); at_neg();
        chk("abandoned op_data", op_data, 8'h00);
        rst_n = 1'b1;
        repeat (3) cyc();
        at_neg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
